// File: rtl/systolic_mac_array.sv
// CH-channel, TAPS-wide dot-product engine: input register, multiply and accumulate stages,
// multi-beat group accumulation, then scale / saturate / optional ReLU behind a valid/ready output.
module systolic_mac_array #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 3,
    parameter int CH     = 8,
    parameter int ACC_W  = 40,
    parameter int FRAC   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAPS*DATA_W-1:0]    in_data,
    input  logic [CH*TAPS*DATA_W-1:0] weight,
    input  logic [7:0]                acc_len,
    input  logic                      relu_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH*DATA_W-1:0]      out_data,
    output logic                      busy
);
    localparam int PW = 2 * DATA_W;
    localparam int NP = CH * TAPS;

    function automatic logic signed [PW-1:0] mul_s(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = {{DATA_W{a[DATA_W-1]}}, a};
        bx = {{DATA_W{b[DATA_W-1]}}, b};
        return ax * bx;
    endfunction

    // Floor shift, clamp to the signed element range, then optional ReLU.
    function automatic logic [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] a,
                                                    input logic relu);
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        logic [DATA_W-1:0]       res;
        r  = a >>> FRAC;
        hi = '0;
        hi[DATA_W-2:0] = '1;
        lo = '1;
        lo[DATA_W-2:0] = '0;
        if (r > hi) begin
            res = hi[DATA_W-1:0];
        end else if (r < lo) begin
            res = lo[DATA_W-1:0];
        end else begin
            res = r[DATA_W-1:0];
        end
        return (relu && r[ACC_W-1]) ? '0 : res;
    endfunction

    logic [7:0]                cnt_q, cnt_d, len_q, len_d, len_s;
    logic                      relu_q, relu_d, relu_s;
    logic                      stall_s, accept_s, last_s, load_s;
    logic                      s0_valid_q, s0_valid_d, s0_last_q, s0_last_d, s0_relu_q, s0_relu_d;
    logic [TAPS*DATA_W-1:0]    s0_data_q, s0_data_d;
    logic [CH*TAPS*DATA_W-1:0] s0_wt_q, s0_wt_d;
    logic                      s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_relu_q, s1_relu_d;
    logic signed [PW-1:0]      prod_q [NP];
    logic signed [PW-1:0]      prod_d [NP];
    logic signed [ACC_W-1:0]   acc_q [CH];
    logic signed [ACC_W-1:0]   acc_d [CH];
    logic signed [ACC_W-1:0]   sum_s [CH];
    logic signed [ACC_W-1:0]   acc_next_s [CH];
    logic                      out_valid_q, out_valid_d;
    logic [CH*DATA_W-1:0]      out_data_q, out_data_d;

    // Handshake, beat counter and group parameter latching (taken live on a group's first beat).
    always_comb begin
        stall_s  = out_valid_q && !out_ready;
        accept_s = in_valid && !stall_s;
        cnt_d    = cnt_q;
        len_d    = len_q;
        relu_d   = relu_q;
        if (cnt_q == 8'd0) begin
            len_s  = (acc_len == 8'd0) ? 8'd1 : acc_len;
            relu_s = relu_en;
        end else begin
            len_s  = len_q;
            relu_s = relu_q;
        end
        last_s = (cnt_q == (len_s - 8'd1));
        if (accept_s) begin
            cnt_d  = last_s ? 8'd0 : (cnt_q + 8'd1);
            len_d  = len_s;
            relu_d = relu_s;
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Input register and multiply stage; everything holds while the output is stalled.
    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_last_d  = s0_last_q;
        s0_relu_d  = s0_relu_q;
        s0_data_d  = s0_data_q;
        s0_wt_d    = s0_wt_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_relu_d  = s1_relu_q;
        for (int i = 0; i < NP; i++) begin
            prod_d[i] = prod_q[i];
        end
        if (!stall_s) begin
            s0_valid_d = accept_s;
            s0_last_d  = accept_s && last_s;
            s0_relu_d  = relu_s;
            if (accept_s) begin
                s0_data_d = in_data;
                s0_wt_d   = weight;
            end else begin
                s0_data_d = s0_data_q;
                s0_wt_d   = s0_wt_q;
            end
            s1_valid_d = s0_valid_q;
            s1_last_d  = s0_last_q;
            s1_relu_d  = s0_relu_q;
            for (int c = 0; c < CH; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    prod_d[c*TAPS+t] = mul_s(s0_data_q[t*DATA_W +: DATA_W],
                                             s0_wt_q[(c*TAPS+t)*DATA_W +: DATA_W]);
                end
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Accumulate stage and output register; a last beat both loads the result and clears acc.
    always_comb begin
        load_s     = !stall_s && s1_valid_q && s1_last_q;
        out_data_d = out_data_q;
        for (int c = 0; c < CH; c++) begin
            sum_s[c] = '0;
            for (int t = 0; t < TAPS; t++) begin
                sum_s[c] = sum_s[c] + {{(ACC_W-PW){prod_q[c*TAPS+t][PW-1]}}, prod_q[c*TAPS+t]};
            end
            acc_next_s[c] = acc_q[c] + sum_s[c];
            if (!stall_s && s1_valid_q) begin
                acc_d[c] = s1_last_q ? '0 : acc_next_s[c];
            end else begin
                acc_d[c] = acc_q[c];
            end
            if (load_s) begin
                out_data_d[c*DATA_W +: DATA_W] = scale_sat(acc_next_s[c], s1_relu_q);
            end else begin
                out_data_d[c*DATA_W +: DATA_W] = out_data_q[c*DATA_W +: DATA_W];
            end
        end
        if (stall_s) begin
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = load_s;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 8'd0;
            len_q       <= 8'd0;
            relu_q      <= 1'b0;
            s0_valid_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_relu_q   <= 1'b0;
            s0_data_q   <= '0;
            s0_wt_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_relu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < NP; i++) begin
                prod_q[i] <= '0;
            end
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            relu_q      <= relu_d;
            s0_valid_q  <= s0_valid_d;
            s0_last_q   <= s0_last_d;
            s0_relu_q   <= s0_relu_d;
            s0_data_q   <= s0_data_d;
            s0_wt_q     <= s0_wt_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_relu_q   <= s1_relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < NP; i++) begin
                prod_q[i] <= prod_d[i];
            end
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign in_ready  = !stall_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != 8'd0) || s0_valid_q || s1_valid_q;

endmodule
